// File: rtl/gray_capture_sync.sv
// Captures an asynchronous 4-bit Gray code through a 2-flop synchroniser and a stability filter, then checks each new code for a legal single-bit step.
// Latency: STABLE_CYCLES+3 edges from input to GRAY. Backpressure: a one-entry pending buffer absorbs one stalled code; further codes overwrite it and set ovf_err.
module gray_capture_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] gray_in,
  input  logic       gray_ready,
  input  logic       err_clr,
  output logic [3:0] GRAY,
  output logic       gray_valid,
  output logic       step_err,
  output logic       ovf_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       r_s1, r_s2, r_cand, r_acc, r_pend, r_gray;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first, r_pend_full, r_vld, r_step, r_ovf;

  logic       w_accept, w_step_bad, w_ovf_set;
  logic [3:0] w_diff;

  assign w_diff     = r_cand ^ r_acc;
  assign w_accept   = (r_cnt == CNT_MAX) && (r_s2 == r_cand) && (r_first || (r_cand != r_acc));
  assign w_step_bad = !r_first && ($countones(w_diff) != 1);
  // Overflow only when the buffer is already full and nothing drains this edge.
  assign w_ovf_set  = w_accept && r_vld && !gray_ready && r_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= gray_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_s2 != r_cand) begin
      r_cand <= r_s2;
      r_cnt  <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_acc   <= r_cand;
      r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray      <= '0;
      r_vld       <= 1'b0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (!r_vld) begin
      if (w_accept) begin
        r_gray <= r_cand;
        r_vld  <= 1'b1;
      end
    end else if (gray_ready) begin
      if (r_pend_full) begin
        r_gray <= r_pend;
        if (w_accept) r_pend <= r_cand;
        else          r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_gray <= r_cand;
      end else begin
        r_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_pend      <= r_cand;
      r_pend_full <= 1'b1;
    end
  end

  // A new error at the same edge as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_step <= (r_step && !err_clr) || (w_accept && w_step_bad);
      r_ovf  <= (r_ovf && !err_clr) || w_ovf_set;
    end
  end

  assign GRAY       = r_gray;
  assign gray_valid = r_vld;
  assign step_err   = r_step;
  assign ovf_err    = r_ovf;

endmodule
